// File: rtl/id_ex_operand_stage_pkg.sv
// Shared constants for the ID/EX operand stage.
// ALU op codes, operand-select encodings and default widths.
package id_ex_operand_stage_pkg;

    localparam int ALU_OP_W = 4;
    localparam int REG_AW   = 5;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_SLL   = 4'd0,
        ALU_SRL   = 4'd1,
        ALU_SRA   = 4'd2,
        ALU_PASSB = 4'd3,
        ALU_ADD   = 4'd4,
        ALU_SUB   = 4'd5,
        ALU_AND   = 4'd6,
        ALU_OR    = 4'd7,
        ALU_XOR   = 4'd8,
        ALU_NOR   = 4'd9,
        ALU_SLT   = 4'd10,
        ALU_AUI   = 4'd11
    } alu_op_e;

    localparam logic [1:0] A_SEL_RS    = 2'd0;
    localparam logic [1:0] A_SEL_SHAMT = 2'd1;
    localparam logic [1:0] A_SEL_PC    = 2'd2;
    localparam logic [1:0] A_SEL_ZERO  = 2'd3;

    localparam logic B_SEL_RT  = 1'b0;
    localparam logic B_SEL_IMM = 1'b1;

endpackage

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// One source operand forwarding mux.
// EX/MEM beats MEM/WB beats the registered value; $0 never forwards.
module id_ex_operand_stage_fwd_mux #(
    parameter int AW = 5
) (
    input  logic [AW-1:0] src_i,
    input  logic [31:0]   reg_data_i,
    input  logic          exmem_we_i,
    input  logic [AW-1:0] exmem_rd_i,
    input  logic [31:0]   exmem_data_i,
    input  logic          memwb_we_i,
    input  logic [AW-1:0] memwb_rd_i,
    input  logic [31:0]   memwb_data_i,
    output logic [31:0]   data_o
);

    logic src_nz;

    assign src_nz = (src_i != '0);

    // Pick the youngest in-flight write to this source register.
    always_comb begin
        data_o = reg_data_i;
        if (src_nz && exmem_we_i && (exmem_rd_i == src_i)) begin
            data_o = exmem_data_i;
        end else if (src_nz && memwb_we_i && (memwb_rd_i == src_i)) begin
            data_o = memwb_data_i;
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with forwarding and ALU operand select.
// Define ID_EX_FWD_EN for forwarding; otherwise RAW hazards stall.
module id_ex_operand_stage #(
    parameter int ALU_OP_W = id_ex_operand_stage_pkg::ALU_OP_W,
    parameter int REG_AW   = id_ex_operand_stage_pkg::REG_AW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                flush,
    input  logic                id_valid,
    input  logic [31:0]         id_pc,
    input  logic [REG_AW-1:0]   id_rs,
    input  logic [REG_AW-1:0]   id_rt,
    input  logic [31:0]         id_rs_data,
    input  logic [31:0]         id_rt_data,
    input  logic                id_use_rs,
    input  logic                id_use_rt,
    input  logic [31:0]         id_imm,
    input  logic [4:0]          id_shamt,
    input  logic [ALU_OP_W-1:0] id_alu_op,
    input  logic [1:0]          id_a_sel,
    input  logic                id_b_sel,
    input  logic [REG_AW-1:0]   id_rd_dst,
    input  logic                id_reg_write,
    input  logic                id_mem_read,
    input  logic                id_mem_write,
    input  logic                exmem_reg_write,
    input  logic [REG_AW-1:0]   exmem_rd,
    input  logic [31:0]         exmem_result,
    input  logic                memwb_reg_write,
    input  logic [REG_AW-1:0]   memwb_rd,
    input  logic [31:0]         memwb_data,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [31:0]         alu_a,
    output logic [31:0]         alu_b,
    output logic                ex_valid,
    output logic [31:0]         ex_pc,
    output logic [31:0]         ex_store_data,
    output logic [REG_AW-1:0]   ex_rd,
    output logic                ex_reg_write,
    output logic                ex_mem_read,
    output logic                ex_mem_write,
    output logic                hazard_stall
);

    import id_ex_operand_stage_pkg::*;

    typedef struct packed {
        logic                valid;
        logic [31:0]         pc;
        logic [ALU_OP_W-1:0] op;
        logic [REG_AW-1:0]   rs;
        logic [REG_AW-1:0]   rt;
        logic [31:0]         rs_data;
        logic [31:0]         rt_data;
        logic [31:0]         imm;
        logic [4:0]          shamt;
        logic [1:0]          a_sel;
        logic                b_sel;
        logic [REG_AW-1:0]   rd;
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
    } id_ex_t;

    id_ex_t      ex_q;
    id_ex_t      ex_d;
    id_ex_t      id_in;
    logic [31:0] fwd_rs;
    logic [31:0] fwd_rt;

    function automatic logic raw_hit(
        input logic              we,
        input logic [REG_AW-1:0] rd,
        input logic              v,
        input logic              use_rs,
        input logic [REG_AW-1:0] rs,
        input logic              use_rt,
        input logic [REG_AW-1:0] rt
    );
        return we && v && (rd != '0) &&
               ((use_rs && (rs == rd)) || (use_rt && (rt == rd)));
    endfunction

    // Bundle the ID-side fields into the captured record.
    always_comb begin
        id_in           = '0;
        id_in.valid     = id_valid;
        id_in.pc        = id_pc;
        id_in.op        = id_alu_op;
        id_in.rs        = id_rs;
        id_in.rt        = id_rt;
        id_in.rs_data   = id_rs_data;
        id_in.rt_data   = id_rt_data;
        id_in.imm       = id_imm;
        id_in.shamt     = id_shamt;
        id_in.a_sel     = id_a_sel;
        id_in.b_sel     = id_b_sel;
        id_in.rd        = id_rd_dst;
        id_in.reg_write = id_reg_write;
        id_in.mem_read  = id_mem_read;
        id_in.mem_write = id_mem_write;
    end

`ifdef ID_EX_FWD_EN
    id_ex_operand_stage_fwd_mux #(
        .AW(REG_AW)
    ) u_fwd_rs (
        .src_i       (ex_q.rs),
        .reg_data_i  (ex_q.rs_data),
        .exmem_we_i  (exmem_reg_write),
        .exmem_rd_i  (exmem_rd),
        .exmem_data_i(exmem_result),
        .memwb_we_i  (memwb_reg_write),
        .memwb_rd_i  (memwb_rd),
        .memwb_data_i(memwb_data),
        .data_o      (fwd_rs)
    );

    id_ex_operand_stage_fwd_mux #(
        .AW(REG_AW)
    ) u_fwd_rt (
        .src_i       (ex_q.rt),
        .reg_data_i  (ex_q.rt_data),
        .exmem_we_i  (exmem_reg_write),
        .exmem_rd_i  (exmem_rd),
        .exmem_data_i(exmem_result),
        .memwb_we_i  (memwb_reg_write),
        .memwb_rd_i  (memwb_rd),
        .memwb_data_i(memwb_data),
        .data_o      (fwd_rt)
    );

    // Only a load still in EX cannot be forwarded in time.
    assign hazard_stall = raw_hit(ex_q.valid & ex_q.mem_read & ex_q.reg_write,
                                  ex_q.rd, id_valid,
                                  id_use_rs, id_rs, id_use_rt, id_rt);
`else
    logic unused_fwd_data;

    assign fwd_rs = ex_q.rs_data;
    assign fwd_rt = ex_q.rt_data;
    assign unused_fwd_data = ^{exmem_result, memwb_data, ex_q.rs, ex_q.rt};

    // Without forwarding, any pending writer of a source must drain first.
    assign hazard_stall =
        raw_hit(ex_q.valid & ex_q.reg_write, ex_q.rd, id_valid,
                id_use_rs, id_rs, id_use_rt, id_rt) |
        raw_hit(exmem_reg_write, exmem_rd, id_valid,
                id_use_rs, id_rs, id_use_rt, id_rt) |
        raw_hit(memwb_reg_write, memwb_rd, id_valid,
                id_use_rs, id_rs, id_use_rt, id_rt);
`endif

    // Next-state: flush > stall > load-use bubble > load.
    always_comb begin
        ex_d = ex_q;
        if (flush) begin
            ex_d.valid = 1'b0;
        end else if (stall) begin
            ex_d.rs_data = fwd_rs;
            ex_d.rt_data = fwd_rt;
        end else if (hazard_stall) begin
            ex_d.valid = 1'b0;
        end else begin
            ex_d = id_in;
        end
    end

    // Stage register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    // ALU operand A select.
    always_comb begin
        alu_a = '0;
        unique case (ex_q.a_sel)
            A_SEL_RS:    alu_a = fwd_rs;
            A_SEL_SHAMT: alu_a = {27'b0, ex_q.shamt};
            A_SEL_PC:    alu_a = ex_q.pc;
            A_SEL_ZERO:  alu_a = '0;
            default:     alu_a = '0;
        endcase
    end

    assign alu_b         = (ex_q.b_sel == B_SEL_IMM) ? ex_q.imm : fwd_rt;
    assign alu_op        = ex_q.op;
    assign ex_valid      = ex_q.valid;
    assign ex_pc         = ex_q.pc;
    assign ex_store_data = fwd_rt;
    assign ex_rd         = ex_q.rd;
    assign ex_reg_write  = ex_q.valid & ex_q.reg_write;
    assign ex_mem_read   = ex_q.valid & ex_q.mem_read;
    assign ex_mem_write  = ex_q.valid & ex_q.mem_write;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage.
// Follows ID_EX_FWD_EN the same way as the design.
module tb_id_ex_operand_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic        id_use_rs;
    logic        id_use_rt;
    logic [31:0] id_imm;
    logic [4:0]  id_shamt;
    logic [3:0]  id_alu_op;
    logic [1:0]  id_a_sel;
    logic        id_b_sel;
    logic [4:0]  id_rd_dst;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        id_mem_write;
    logic        exmem_reg_write;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_result;
    logic        memwb_reg_write;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_data;
    logic [3:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        hazard_stall;

    int n_checks = 0;
    int n_fail   = 0;

    id_ex_operand_stage #(
        .ALU_OP_W(4),
        .REG_AW  (5)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .flush          (flush),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_rs_data     (id_rs_data),
        .id_rt_data     (id_rt_data),
        .id_use_rs      (id_use_rs),
        .id_use_rt      (id_use_rt),
        .id_imm         (id_imm),
        .id_shamt       (id_shamt),
        .id_alu_op      (id_alu_op),
        .id_a_sel       (id_a_sel),
        .id_b_sel       (id_b_sel),
        .id_rd_dst      (id_rd_dst),
        .id_reg_write   (id_reg_write),
        .id_mem_read    (id_mem_read),
        .id_mem_write   (id_mem_write),
        .exmem_reg_write(exmem_reg_write),
        .exmem_rd       (exmem_rd),
        .exmem_result   (exmem_result),
        .memwb_reg_write(memwb_reg_write),
        .memwb_rd       (memwb_rd),
        .memwb_data     (memwb_data),
        .alu_op         (alu_op),
        .alu_a          (alu_a),
        .alu_b          (alu_b),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_store_data  (ex_store_data),
        .ex_rd          (ex_rd),
        .ex_reg_write   (ex_reg_write),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_write   (ex_mem_write),
        .hazard_stall   (hazard_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: contents of the EX slot.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [3:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] rsd;
        logic [31:0] rtd;
        logic [31:0] imm;
        logic [4:0]  shamt;
        logic [1:0]  asel;
        logic        bsel;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
    } m_t;

    m_t m;

    function automatic logic [31:0] m_src(input logic [4:0] r,
                                          input logic [31:0] regd);
`ifdef ID_EX_FWD_EN
        if (exmem_reg_write && r != 0 && exmem_rd == r) return exmem_result;
        if (memwb_reg_write && r != 0 && memwb_rd == r) return memwb_data;
`endif
        return regd;
    endfunction

    function automatic logic m_reads(input logic [4:0] r);
        return id_valid && r != 0 &&
               ((id_use_rs && id_rs == r) || (id_use_rt && id_rt == r));
    endfunction

    function automatic logic m_hazard();
`ifdef ID_EX_FWD_EN
        return m.valid && m.mr && m.rw && m_reads(m.rd);
`else
        return (m.valid && m.rw && m_reads(m.rd)) ||
               (exmem_reg_write && m_reads(exmem_rd)) ||
               (memwb_reg_write && m_reads(memwb_rd));
`endif
    endfunction

    function automatic logic [31:0] m_alu_a();
        case (m.asel)
            2'd0:    return m_src(m.rs, m.rsd);
            2'd1:    return {27'd0, m.shamt};
            2'd2:    return m.pc;
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_step();
        m_t n;
        n = m;
        if (flush) begin
            n.valid = 1'b0;
        end else if (stall) begin
            n.rsd = m_src(m.rs, m.rsd);
            n.rtd = m_src(m.rt, m.rtd);
        end else if (m_hazard()) begin
            n.valid = 1'b0;
        end else begin
            n = '{id_valid, id_pc, id_alu_op, id_rs, id_rt, id_rs_data,
                  id_rt_data, id_imm, id_shamt, id_a_sel, id_b_sel,
                  id_rd_dst, id_reg_write, id_mem_read, id_mem_write};
        end
        m = n;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_in();
        stall = 0; flush = 0; id_valid = 0; id_pc = 0;
        id_rs = 0; id_rt = 0; id_rs_data = 0; id_rt_data = 0;
        id_use_rs = 0; id_use_rt = 0; id_imm = 0; id_shamt = 0;
        id_alu_op = 0; id_a_sel = 0; id_b_sel = 0; id_rd_dst = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
        exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_data = 0;
    endtask

    task automatic drain();
        clear_in();
        flush = 1;
        step();
        flush = 0;
    endtask

    task automatic drive_id(input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [31:0] rsd,
                            input logic [31:0] rtd, input logic [3:0] op,
                            input logic [1:0] asel, input logic bsel,
                            input logic mr, input logic mw);
        id_valid = 1; id_pc = 32'h400; id_imm = 32'h1234; id_shamt = 0;
        id_rs = rs; id_rt = rt; id_rd_dst = rd;
        id_rs_data = rsd; id_rt_data = rtd;
        id_use_rs = 1; id_use_rt = 1;
        id_alu_op = op; id_a_sel = asel; id_b_sel = bsel;
        id_reg_write = !mw; id_mem_read = mr; id_mem_write = mw;
    endtask

    task automatic test_reset();
        logic [141:0] got;
        rst = 1;
        clear_in();
        repeat (2) step();
        #1;
        got = {ex_valid, ex_pc, alu_op, alu_a, alu_b, ex_store_data,
               ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, hazard_stall};
        n_checks++;
        if (got !== '0) begin
            n_fail++;
            $display("FAIL reset_state got=%h exp=0", got);
        end
        rst = 0;
        drive_id(1, 2, 3, 32'd7, 32'd9, 4'd4, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        #1;
        n_checks++;
        if ({ex_valid, alu_a, alu_b, ex_reg_write} !== {1'b1, 32'd7, 32'd9, 1'b1}) begin
            n_fail++;
            $display("FAIL pre_reset_add got=%b/%h/%h/%b exp=1/7/9/1",
                     ex_valid, alu_a, alu_b, ex_reg_write);
        end
        rst = 1;
        #1;
        n_checks++;
        if ({ex_valid, alu_a, alu_b, ex_reg_write} !== 66'd0) begin
            n_fail++;
            $display("FAIL async_reset got=%b/%h/%h/%b exp=0/0/0/0",
                     ex_valid, alu_a, alu_b, ex_reg_write);
        end
        step();
        rst = 0;
        clear_in();
    endtask

    task automatic test_exmem_fwd();
        drain();
        drive_id(1, 3, 2, 32'd0, 32'd5, 4'd4, 2'd0, 1'b0, 1'b0, 1'b0);
        exmem_reg_write = 1; exmem_rd = 1; exmem_result = 32'h10;
        #1;
`ifdef ID_EX_FWD_EN
        n_checks++;
        if (hazard_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL exmem_no_stall got=%b exp=0", hazard_stall);
        end
        step();
        id_valid = 0;
        #1;
        n_checks++;
        if ({alu_op, alu_a, alu_b} !== {4'd4, 32'h10, 32'd5}) begin
            n_fail++;
            $display("FAIL exmem_fwd got=%h/%h/%h exp=4/10/5", alu_op, alu_a, alu_b);
        end
`else
        n_checks++;
        if (hazard_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL exmem_raw_stall got=%b exp=1", hazard_stall);
        end
        step();
        exmem_reg_write = 0;
        #1;
        n_checks++;
        if ({ex_valid, hazard_stall} !== 2'b00) begin
            n_fail++;
            $display("FAIL exmem_bubble got=%b%b exp=00", ex_valid, hazard_stall);
        end
        step();
        id_valid = 0;
        #1;
        n_checks++;
        if ({ex_valid, alu_op, alu_a, alu_b} !== {1'b1, 4'd4, 32'd0, 32'd5}) begin
            n_fail++;
            $display("FAIL exmem_after_drain got=%b/%h/%h/%h exp=1/4/0/5",
                     ex_valid, alu_op, alu_a, alu_b);
        end
`endif
    endtask

    task automatic test_double_hit();
        drain();
`ifdef ID_EX_FWD_EN
        drive_id(4, 5, 6, 32'h11, 32'h22, 4'd4, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        id_valid = 0;
        exmem_reg_write = 1; exmem_rd = 4; exmem_result = 32'hAA;
        memwb_reg_write = 1; memwb_rd = 4; memwb_data = 32'hBB;
        #1;
        n_checks++;
        if (alu_a !== 32'hAA) begin
            n_fail++;
            $display("FAIL double_hit got=%h exp=aa", alu_a);
        end
        exmem_reg_write = 0;
        #1;
        n_checks++;
        if (alu_a !== 32'hBB) begin
            n_fail++;
            $display("FAIL memwb_only got=%h exp=bb", alu_a);
        end
        drive_id(0, 5, 6, 32'h33, 32'h22, 4'd4, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        id_valid = 0;
        exmem_reg_write = 1; exmem_rd = 0; exmem_result = 32'h55;
        memwb_reg_write = 1; memwb_rd = 0; memwb_data = 32'h66;
        #1;
        n_checks++;
        if (alu_a !== 32'h33) begin
            n_fail++;
            $display("FAIL reg0_no_fwd got=%h exp=33", alu_a);
        end
`else
        drive_id(4, 5, 6, 32'h11, 32'h22, 4'd4, 2'd0, 1'b0, 1'b0, 1'b0);
        memwb_reg_write = 1; memwb_rd = 4; memwb_data = 32'hBB;
        #1;
        n_checks++;
        if (hazard_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL memwb_raw_stall got=%b exp=1", hazard_stall);
        end
        memwb_reg_write = 0;
        step();
        id_valid = 0;
        exmem_reg_write = 1; exmem_rd = 4; exmem_result = 32'hAA;
        #1;
        n_checks++;
        if (alu_a !== 32'h11) begin
            n_fail++;
            $display("FAIL no_fwd_path got=%h exp=11", alu_a);
        end
        drive_id(0, 0, 6, 32'h33, 32'h22, 4'd4, 2'd0, 1'b0, 1'b0, 1'b0);
        exmem_rd = 0;
        memwb_reg_write = 1; memwb_rd = 0;
        #1;
        n_checks++;
        if (hazard_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reg0_no_stall got=%b exp=0", hazard_stall);
        end
`endif
    endtask

    task automatic test_load_use();
        drain();
        drive_id(6, 0, 5, 32'h1000, 32'd0, 4'd4, 2'd0, 1'b1, 1'b1, 1'b0);
        id_use_rt = 0;
        step();
        drive_id(5, 7, 8, 32'd0, 32'd2, 4'd4, 2'd0, 1'b0, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (hazard_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL load_use_stall got=%b exp=1", hazard_stall);
        end
        step();
        exmem_reg_write = 1; exmem_rd = 5; exmem_result = 32'h1000;
        #1;
`ifdef ID_EX_FWD_EN
        n_checks++;
        if ({ex_valid, hazard_stall} !== 2'b00) begin
            n_fail++;
            $display("FAIL load_use_bubble got=%b%b exp=00", ex_valid, hazard_stall);
        end
        step();
        exmem_reg_write = 0;
        memwb_reg_write = 1; memwb_rd = 5; memwb_data = 32'hDEAD;
        id_valid = 0;
`else
        n_checks++;
        if ({ex_valid, hazard_stall} !== 2'b01) begin
            n_fail++;
            $display("FAIL raw_in_mem got=%b%b exp=01", ex_valid, hazard_stall);
        end
        step();
        exmem_reg_write = 0;
        memwb_reg_write = 1; memwb_rd = 5; memwb_data = 32'hDEAD;
        #1;
        n_checks++;
        if (hazard_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL raw_in_wb got=%b exp=1", hazard_stall);
        end
        step();
        memwb_reg_write = 0;
        id_rs_data = 32'hDEAD;
        step();
        id_valid = 0;
`endif
        #1;
        n_checks++;
        if ({ex_valid, alu_a, alu_b} !== {1'b1, 32'hDEAD, 32'd2}) begin
            n_fail++;
            $display("FAIL load_use_enter got=%b/%h/%h exp=1/dead/2",
                     ex_valid, alu_a, alu_b);
        end
    endtask

    task automatic test_stall_wb();
        logic [31:0] exp_a;
`ifdef ID_EX_FWD_EN
        exp_a = 32'h77;
`else
        exp_a = 32'h1;
`endif
        drain();
        drive_id(9, 0, 10, 32'h1, 32'h3, 4'd4, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        id_valid = 0;
        stall = 1;
        memwb_reg_write = 1; memwb_rd = 9; memwb_data = 32'h77;
        step();
        memwb_reg_write = 0;
        step();
        step();
        stall = 0;
        #1;
        n_checks++;
        if ({ex_valid, alu_a} !== {1'b1, exp_a}) begin
            n_fail++;
            $display("FAIL stall_wb_hold got=%b/%h exp=1/%h", ex_valid, alu_a, exp_a);
        end
    endtask

    task automatic test_flush_stall();
        drain();
        drive_id(1, 2, 0, 32'd5, 32'd6, 4'd4, 2'd0, 1'b1, 1'b0, 1'b1);
        step();
        #1;
        n_checks++;
        if ({ex_valid, ex_mem_write, ex_store_data} !== {2'b11, 32'd6}) begin
            n_fail++;
            $display("FAIL store_enter got=%b%b/%h exp=11/6",
                     ex_valid, ex_mem_write, ex_store_data);
        end
        drive_id(3, 4, 5, 32'd1, 32'd2, 4'd4, 2'd0, 1'b0, 1'b0, 1'b1);
        flush = 1; stall = 1;
        step();
        flush = 0; stall = 0; id_valid = 0;
        #1;
        n_checks++;
        if ({ex_valid, ex_mem_write, ex_reg_write} !== 3'b000) begin
            n_fail++;
            $display("FAIL flush_stall got=%b%b%b exp=000",
                     ex_valid, ex_mem_write, ex_reg_write);
        end
    endtask

    task automatic test_shift();
        drain();
        drive_id(0, 2, 4, 32'd0, 32'h80, 4'd0, 2'd1, 1'b0, 1'b0, 1'b0);
        id_shamt = 5'd3;
        id_use_rs = 0;
        step();
        drive_id(1, 2, 4, 32'd9, 32'h80, 4'd11, 2'd2, 1'b1, 1'b0, 1'b0);
        #1;
        n_checks++;
        if ({alu_op, alu_a, alu_b, ex_store_data} !== {4'd0, 32'd3, 32'h80, 32'h80}) begin
            n_fail++;
            $display("FAIL shift_sll got=%h/%h/%h/%h exp=0/3/80/80",
                     alu_op, alu_a, alu_b, ex_store_data);
        end
        step();
        id_valid = 0;
        #1;
        n_checks++;
        if ({alu_op, alu_a, alu_b} !== {4'd11, 32'h400, 32'h1234}) begin
            n_fail++;
            $display("FAIL pc_imm_sel got=%h/%h/%h exp=b/400/1234", alu_op, alu_a, alu_b);
        end
    endtask

    task automatic test_random();
        logic [141:0] got;
        logic [141:0] exp;
        logic [31:0]  ea;
        logic [31:0]  ert;
        clear_in();
        rst = 1;
        step();
        rst = 0;
        m = '0;
        for (int c = 0; c < 1500; c++) begin
            stall = ($urandom_range(9) == 0);
            flush = ($urandom_range(19) == 0);
            id_valid = ($urandom_range(9) < 8);
            id_pc = $urandom;
            id_rs = 5'($urandom_range(7));
            id_rt = 5'($urandom_range(7));
            id_rs_data = $urandom;
            id_rt_data = $urandom;
            id_use_rs = 1'($urandom_range(1));
            id_use_rt = 1'($urandom_range(1));
            id_imm = $urandom;
            id_shamt = 5'($urandom_range(31));
            id_alu_op = 4'($urandom_range(11));
            id_a_sel = 2'($urandom_range(3));
            id_b_sel = 1'($urandom_range(1));
            id_rd_dst = 5'($urandom_range(7));
            id_reg_write = 1'($urandom_range(1));
            id_mem_read = ($urandom_range(2) == 0);
            id_mem_write = ($urandom_range(3) == 0);
            exmem_reg_write = 1'($urandom_range(1));
            exmem_rd = 5'($urandom_range(7));
            exmem_result = $urandom;
            memwb_reg_write = 1'($urandom_range(1));
            memwb_rd = 5'($urandom_range(7));
            memwb_data = $urandom;
            #1;
            if (m.valid) begin
                ea = m_alu_a();
                ert = m_src(m.rt, m.rtd);
                got = {ex_valid, ex_pc, alu_op, alu_a, alu_b, ex_store_data,
                       ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, hazard_stall};
                exp = {1'b1, m.pc, m.op, ea, m.bsel ? m.imm : ert, ert,
                       m.rd, m.rw, m.mr, m.mw, m_hazard()};
                n_checks++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL rand_full cyc=%0d got=%h exp=%h", c, got, exp);
                end
            end else begin
                n_checks++;
                if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, hazard_stall}
                    !== {4'b0000, m_hazard()}) begin
                    n_fail++;
                    $display("FAIL rand_empty cyc=%0d got=%b%b%b%b%b exp=0000%b", c,
                             ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
                             hazard_stall, m_hazard());
                end
            end
            m_step();
            step();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout bench did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_exmem_fwd();
        test_double_hit();
        test_load_use();
        test_stall_wb();
        test_flush_stall();
        test_shift();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
